bcd2hex_seq: RTL and testbench

- Sequential BCD-to-binary converter. It is the inverse of the binary-to-BCD display path.
- Accepts a packed NDIGITS-digit BCD word over a valid/ready handshake.
- Converts most-significant digit first, one digit per cycle, using acc <= acc*10 + digit.
- Presents a saturated HEX_W-bit binary result with overflow and invalid-digit flags over a second valid/ready handshake. Sits between keypad/BCD entry logic and binary datapath consumers.

---
 rtl/bcd2hex_seq_pkg.sv | 29 ++
 rtl/bcd2hex_seq_if.sv | 28 ++
 rtl/bcd2hex_seq_mac_step.sv | 19 +
 rtl/bcd2hex_seq.sv | 130 +++++++++++++
 tb/tb_bcd2hex_seq.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd2hex_seq_pkg.sv
// Shared BCD definitions: digit geometry, converter FSM states and the
// accumulator-width rule used by the elaboration-time checks.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned BCD_MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  // Smallest w with 2^w > 10^ndigits - 1, so acc*10+d never wraps.
  function automatic int unsigned min_acc_w(input int unsigned ndigits);
    longint unsigned pow10;
    int unsigned     w;
    pow10 = 1;
    for (int unsigned i = 0; i < ndigits; i++) begin
      pow10 = pow10 * 10;
    end
    w = 0;
    while ((64'd1 << w) < pow10) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd2hex_seq_if.sv
// Input/output handshake bundle of the BCD-to-binary converter.
interface bcd2hex_seq_if
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS = 3,
  parameter int unsigned HEX_W   = 8
);

  logic                           in_valid;
  logic                           in_ready;
  logic [BCD_DIGIT_W*NDIGITS-1:0] bcd_in;
  logic                           out_valid;
  logic                           out_ready;
  logic [HEX_W-1:0]               hex;
  logic                           ovf;
  logic                           digit_err;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, hex, ovf, digit_err
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, hex, ovf, digit_err
  );

endinterface

// File: rtl/bcd2hex_seq_mac_step.sv
// One decimal multiply-accumulate step: acc*10 + digit, plus an invalid-digit flag.
module bcd_mac_step
  import bcd_pkg::*;
#(
  parameter int unsigned ACC_W = 10
) (
  input  logic [ACC_W-1:0]       acc_i,
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [ACC_W-1:0]       acc_o,
  output logic                   digit_err_o
);

  // x*10 as x*8 + x*2 keeps this a pair of adders instead of a multiplier.
  always_comb begin
    acc_o       = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit_i);
    digit_err_o = (digit_i > BCD_DIGIT_W'(BCD_MAX_DIGIT));
  end

endmodule

// File: rtl/bcd2hex_seq.sv
// Sequential BCD-to-binary converter: MSD first, one digit per cycle,
// saturated result with overflow and invalid-digit flags.
module bcd2hex_seq
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS = 3,
  parameter int unsigned HEX_W   = 8,
  parameter int unsigned ACC_W   = 10
) (
  input  logic          clock,
  input  logic          rst,
  bcd2hex_seq_if.slave  bus
);

  localparam int unsigned     WORD_W   = BCD_DIGIT_W * NDIGITS;
  localparam int unsigned     CNT_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIGITS - 1);

  if (ACC_W < min_acc_w(NDIGITS)) begin : g_acc_w_check
    $error("bcd2hex_seq: ACC_W too small for NDIGITS");
  end

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [HEX_W-1:0]  hex_q, hex_d;
  logic              ovf_q, ovf_d;
  logic              derr_q, derr_d;
  logic              out_valid_q, out_valid_d;

  logic [ACC_W-1:0]       mac_acc;
  logic                   mac_err;
  logic                   err_final;
  logic                   too_big;

  bcd_mac_step #(
    .ACC_W (ACC_W)
  ) u_mac (
    .acc_i       (acc_q),
    .digit_i     (shreg_q[WORD_W-1 -: BCD_DIGIT_W]),
    .acc_o       (mac_acc),
    .digit_err_o (mac_err)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    hex_d       = hex_q;
    ovf_d       = ovf_q;
    derr_d      = derr_q;
    out_valid_d = out_valid_q;
    err_final   = err_q | mac_err;
    too_big     = ((mac_acc >> HEX_W) != '0);

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shreg_d = bus.bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d   = mac_acc;
        shreg_d = shreg_q << BCD_DIGIT_W;
        err_d   = err_final;
        cnt_d   = cnt_q + 1'b1;
        // Last digit: register the result from this step's combinational values.
        if (cnt_q == LAST_CNT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          derr_d      = err_final;
          ovf_d       = !err_final && too_big;
          if (err_final) begin
            hex_d = '0;
          end else if (too_big) begin
            hex_d = '1;
          end else begin
            hex_d = HEX_W'(mac_acc);
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      hex_q       <= '0;
      ovf_q       <= 1'b0;
      derr_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      hex_q       <= hex_d;
      ovf_q       <= ovf_d;
      derr_q      <= derr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.hex       = hex_q;
  assign bus.ovf       = ovf_q;
  assign bus.digit_err = derr_q;

endmodule

// File: tb/tb_bcd2hex_seq.sv
// Self-checking bench for bcd2hex_seq: directed cases plus a random stream
// checked against a decimal-arithmetic reference model.
module tb_bcd2hex_seq;

  localparam int unsigned NDIGITS = 3;
  localparam int unsigned HEX_W   = 8;
  localparam int unsigned ACC_W   = 10;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [11:0] exp_q[$];

  bcd2hex_seq_if #(.NDIGITS(NDIGITS), .HEX_W(HEX_W)) bus ();

  bcd2hex_seq #(
    .NDIGITS (NDIGITS),
    .HEX_W   (HEX_W),
    .ACC_W   (ACC_W)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {digit_err, ovf, hex} from the decimal value of the word.
  function automatic logic [HEX_W+1:0] ref_model(input logic [11:0] w);
    int unsigned val, scale, d;
    logic        err;
    val = 0; scale = 1; err = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      d = (32'(w) >> (4 * i)) & 32'hF;
      if (d > 9) err = 1'b1;
      val = val + d * scale;
      scale = scale * 10;
    end
    if (err) return {1'b1, 1'b0, 8'h00};
    if (val > 255) return {1'b0, 1'b1, 8'hFF};
    return {2'b00, 8'(val)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [11:0] w, output logic ok);
    bus.in_valid = 1'b1;
    bus.bcd_in   = w;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (bus.in_ready) ok = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic run_one(input logic [11:0] w, input logic [7:0] eh,
                         input logic eo, input logic ee, input string tag);
    logic ok;
    int   n;
    send_word(w, ok);
    check({tag, "_accept"}, 32'(ok), 1);
    wait_result(n);
    check({tag, "_latency"}, n, NDIGITS);
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_hex"}, 32'(bus.hex), 32'(eh));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    check({tag, "_derr"}, 32'(bus.digit_err), 32'(ee));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_ready_back"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    logic ok;
    int   n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.bcd_in    = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_hex", 32'(bus.hex), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    check("rst_derr", 32'(bus.digit_err), 0);

    run_one(12'h255, 8'hFF, 1'b0, 1'b0, "d255");
    run_one(12'h042, 8'h2A, 1'b0, 1'b0, "d042");
    run_one(12'h256, 8'hFF, 1'b1, 1'b0, "d256");
    run_one(12'h999, 8'hFF, 1'b1, 1'b0, "d999");
    run_one(12'h000, 8'h00, 1'b0, 1'b0, "d000");
    run_one(12'h1A3, 8'h00, 1'b0, 1'b1, "d1A3");
    run_one(12'hF00, 8'h00, 1'b0, 1'b1, "dF00");

    // Backpressure with ignored input pulses.
    send_word(12'h128, ok);
    check("bp_accept", 32'(ok), 1);
    wait_result(n);
    check("bp_latency", n, NDIGITS);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = c[0];
      bus.bcd_in   = 12'h777;
      check("bp_valid", 32'(bus.out_valid), 1);
      check("bp_hex", 32'(bus.hex), 32'h80);
      check("bp_ovf", 32'(bus.ovf), 0);
      check("bp_derr", 32'(bus.digit_err), 0);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    check("bp_hold_hex", 32'(bus.hex), 32'h80);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_release_valid", 32'(bus.out_valid), 0);
    check("bp_release_ready", 32'(bus.in_ready), 1);
    run_one(12'h042, 8'h2A, 1'b0, 1'b0, "bp_next");

    // Reset in the middle of a conversion.
    send_word(12'h200, ok);
    check("mrst_accept", 32'(ok), 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_in_ready", 32'(bus.in_ready), 1);
    check("mrst_hex", 32'(bus.hex), 0);
    check("mrst_ovf", 32'(bus.ovf), 0);
    check("mrst_derr", 32'(bus.digit_err), 0);
    for (int c = 0; c < 5; c++) begin
      check("mrst_no_valid", 32'(bus.out_valid), 0);
      tick();
    end
    run_one(12'h199, 8'hC7, 1'b0, 1'b0, "d199");

    // Random stream with random consumer backpressure.
    fork
      begin : producer
        logic [11:0] w;
        logic        pok;
        for (int k = 0; k < 20; k++) begin
          w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
          send_word(w, pok);
          check("rand_accept", 32'(pok), 1);
          if (pok) exp_q.push_back(w);
        end
      end
      begin : consumer
        int           got;
        logic         hs;
        logic [7:0]   h;
        logic         o, e;
        logic [11:0]  w;
        logic [HEX_W+1:0] r;
        got = 0;
        for (int c = 0; c < 4000 && got < 20; c++) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          hs = bus.out_valid && bus.out_ready;
          h  = bus.hex;
          o  = bus.ovf;
          e  = bus.digit_err;
          tick();
          if (hs) begin
            check("rand_queue_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              w = exp_q.pop_front();
              r = ref_model(w);
              check("rand_hex", 32'(h), 32'(r[7:0]));
              check("rand_ovf", 32'(o), 32'(r[8]));
              check("rand_derr", 32'(e), 32'(r[9]));
            end
            got++;
          end
        end
        bus.out_ready = 1'b0;
        check("rand_count", got, 20);
      end
    join
    check("rand_leftover", exp_q.size(), 0);
    for (int c = 0; c < 6; c++) begin
      check("rand_no_dup", 32'(bus.out_valid), 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
